// File: rtl/fp8_dot_accumulator.sv
// FP8 E4M3 product accumulator: S1 decodes each product to fixed point, S2 sums a group and
// posts the result behind a valid/ready output register. Define ACC_SAT_EN for saturating accumulation.
module fp8_dot_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_nan,
    output logic                    out_ovf
);

    logic                    s1_valid;
    logic                    s1_last;
    logic                    s1_nan;
    logic signed [ACC_W-1:0] s1_term;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic                    nan_q;
    logic                    ovf_q;

    logic [3:0]              d_exp;
    logic [2:0]              d_mant;
    logic [17:0]             d_mag;
    logic signed [ACC_W-1:0] d_term;
    logic                    d_nan;

    logic signed [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0]        cnt_next;
    logic                    clamp;

    logic                    stall;
    logic                    s1_fire;
    logic                    accept;

    // A finished group waiting in S1 cannot move while the output register is still owned.
    assign stall    = s1_valid && s1_last && out_valid && !out_ready;
    assign in_ready = !rst && !clear && !stall;
    assign s1_fire  = s1_valid && !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        d_exp  = in_data[6:3];
        d_mant = in_data[2:0];
        d_nan  = (in_data == 8'h80);
        d_mag  = '0;
        if (d_exp != 4'd0) begin
            d_mag = 18'({1'b1, d_mant}) << (d_exp - 4'd1);
        end
        d_term = ACC_W'(d_mag);
        if (in_data[7]) begin
            d_term = -d_term;
        end
    end

`ifdef ACC_SAT_EN
    logic signed [ACC_W:0] wide;

    always_comb begin
        wide     = {acc[ACC_W-1], acc} + {s1_term[ACC_W-1], s1_term};
        sum_next = wide[ACC_W-1:0];
        clamp    = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamp    = 1'b1;
            sum_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        sum_next = acc + s1_term;
        clamp    = 1'b0;
    end
`endif

    assign cnt_next = (count == '1) ? count : count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_term  <= '0;
            acc      <= '0;
            count    <= '0;
            nan_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            acc      <= '0;
            count    <= '0;
            nan_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_last  <= in_last;
                s1_nan   <= d_nan;
                s1_term  <= d_term;
            end else if (s1_fire) begin
                s1_valid <= 1'b0;
            end

            if (s1_fire) begin
                if (s1_last) begin
                    acc   <= '0;
                    count <= '0;
                    nan_q <= 1'b0;
                    ovf_q <= 1'b0;
                end else begin
                    acc   <= sum_next;
                    count <= cnt_next;
                    nan_q <= nan_q | s1_nan;
                    ovf_q <= ovf_q | clamp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_nan   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (s1_fire && s1_last && !clear) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_count <= cnt_next;
            out_nan   <= nan_q | s1_nan;
            out_ovf   <= ovf_q | clamp;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Directed self-checking bench for fp8_dot_accumulator (ACC_W=24, CNT_W=8).
module tb_fp8_dot_accumulator;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clear = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [7:0]              in_data = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_nan;
    logic                    out_ovf;

    int pass_cnt = 0;
    int total    = 0;

    fp8_dot_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_nan(out_nan), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one item until accepted; returns after the accepting edge.
    task automatic push(input logic [7:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL push_timeout: in_ready stayed 0 for data %h", d);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({out_valid, out_sum, out_count, out_nan, out_ovf, in_ready} !== '0)
            $display("FAIL reset_init: v=%b sum=%h cnt=%0d nan=%b ovf=%b rdy=%b",
                     out_valid, out_sum, out_count, out_nan, out_ovf, in_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else pass_cnt++;

        // held result plus a partial group, then reset mid-stream
        push(8'h38, 1'b1);
        tick();
        push(8'h40, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h40;
        rst      = 1'b1;
        #1;
        total++;
        if ({out_valid, out_sum, out_count, out_nan, out_ovf} !== '0)
            $display("FAIL reset_mid_outputs: v=%b sum=%h cnt=%0d nan=%b ovf=%b want all 0",
                     out_valid, out_sum, out_count, out_nan, out_ovf);
        else pass_cnt++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_mid_ready: got %b want 0", in_ready);
        else pass_cnt++;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_mid_release: got %b want 1", in_ready);
        else pass_cnt++;

        push(8'h3C, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000300 || out_count !== 8'd1)
            $display("FAIL reset_partial_lost: v=%b sum=%h cnt=%0d want 1 000300 1",
                     out_valid, out_sum, out_count);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_sum();
        push(8'h38, 1'b0);
        push(8'h40, 1'b0);
        push(8'h3C, 1'b1);
        total++;
        if (out_valid !== 1'b0) $display("FAIL sum_latency_early: out_valid %b want 0", out_valid);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000900 || out_count !== 8'd3 || out_nan !== 1'b0)
            $display("FAIL sum_result: v=%b sum=%h cnt=%0d nan=%b want 1 000900 3 0",
                     out_valid, out_sum, out_count, out_nan);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000900)
            $display("FAIL sum_hold: v=%b sum=%h want 1 000900", out_valid, out_sum);
        else pass_cnt++;
        drain();
        total++;
        if (out_valid !== 1'b0) $display("FAIL sum_consume: out_valid %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_sign_min();
        push(8'hB8, 1'b0);
        push(8'h08, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'hFFFE08 || out_count !== 8'd2)
            $display("FAIL sign_min: v=%b sum=%h cnt=%0d want 1 fffe08 2",
                     out_valid, out_sum, out_count);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_nan();
        push(8'h80, 1'b0);
        push(8'h38, 1'b1);
        tick();
        total++;
        if (out_sum !== 24'h000200 || out_count !== 8'd2 || out_nan !== 1'b1)
            $display("FAIL nan_group: sum=%h cnt=%0d nan=%b want 000200 2 1",
                     out_sum, out_count, out_nan);
        else pass_cnt++;
        drain();
        push(8'h38, 1'b1);
        tick();
        total++;
        if (out_sum !== 24'h000200 || out_count !== 8'd1 || out_nan !== 1'b0)
            $display("FAIL nan_next_group: sum=%h cnt=%0d nan=%b want 000200 1 0",
                     out_sum, out_count, out_nan);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        push(8'h40, 1'b1);
        tick();
        push(8'h38, 1'b0);
        push(8'h38, 1'b1);
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b want 0", in_ready);
        else pass_cnt++;
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000400 || out_count !== 8'd1)
            $display("FAIL bp_hold_a: v=%b sum=%h cnt=%0d want 1 000400 1",
                     out_valid, out_sum, out_count);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000400 || out_count !== 8'd2)
            $display("FAIL bp_group_b: v=%b sum=%h cnt=%0d want 1 000400 2",
                     out_valid, out_sum, out_count);
        else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        push(8'h40, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h38;
        clear    = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL clear_ready: got %b want 0", in_ready);
        else pass_cnt++;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        push(8'h3C, 1'b1);
        tick();
        total++;
        if (out_sum !== 24'h000300 || out_count !== 8'd1)
            $display("FAIL clear_flush: sum=%h cnt=%0d want 000300 1", out_sum, out_count);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_overflow();
        logic [ACC_W-1:0] exp_sum;
        logic             exp_ovf;
`ifdef ACC_SAT_EN
        exp_sum = 24'h7FFFFF;
        exp_ovf = 1'b1;
`else
        exp_sum = 24'h834000;
        exp_ovf = 1'b0;
`endif
        for (int i = 0; i < 35; i++) push(8'h7F, (i == 34));
        tick();
        total++;
        if (out_sum !== exp_sum || out_ovf !== exp_ovf || out_count !== 8'd35)
            $display("FAIL overflow: sum=%h ovf=%b cnt=%0d want %h %b 35",
                     out_sum, out_ovf, out_count, exp_sum, exp_ovf);
        else pass_cnt++;
        drain();
    endtask

    initial begin
        test_reset();
        test_sum();
        test_sign_min();
        test_nan();
        test_backpressure();
        test_clear();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
